// File: rtl/four_bit_seq_divider.sv
// four_bit_seq_divider: restoring divider, 8-bit dividend / 4-bit divisor.
// It produces one quotient bit per clock, MSB first, under a start/busy/done
// handshake. Results are registered and hold until the next completion.
// Optional feature: define FOUR_BIT_SEQ_DIVIDER_DZ_EN to add divide-by-zero
// detection. With it, a zero divisor finishes at the accept edge and raises dz.
// Without it, dz is tied low and a zero divisor runs the normal 8-cycle path.
module four_bit_seq_divider (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Working registers for the operation in flight.
    logic [7:0]  n_reg;
    logic [3:0]  d_reg;
    logic [4:0]  r_reg;
    logic [7:0]  q_reg;
    logic [2:0]  cnt_reg;

    // Published results.
    logic [7:0]  quotient_reg;
    logic [3:0]  remainder_reg;

    // One iteration of the restoring step, computed from the working registers.
    logic [4:0]  r_shift;
    logic        take;
    logic [4:0]  r_step;
    logic [7:0]  q_step;

    logic        accept;
    logic        last_iter;

`ifdef FOUR_BIT_SEQ_DIVIDER_DZ_EN
    logic        div_zero;
    assign div_zero = (divisor == 4'd0);
`else
    localparam logic div_zero = 1'b0;
`endif

    assign accept    = (state_reg == IDLE) && start;
    assign last_iter = (state_reg == CALC) && (cnt_reg == 3'd0);

    // Shift in the next dividend bit, then trial-subtract the divisor.
    always_comb begin
        r_shift = (r_reg << 1) | {4'b0000, n_reg[cnt_reg]};
        take    = (r_shift >= {1'b0, d_reg});
        r_step  = take ? (r_shift - {1'b0, d_reg}) : r_shift;
    end

    // The quotient bit selected by the counter takes the trial result.
    // Every other bit keeps its current value.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_qbit
            assign q_step[gi] = (cnt_reg == 3'(gi)) ? take : q_reg[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. DONE always returns to IDLE, so start is never queued.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == 3'd0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working datapath. Operands are captured at accept, so the inputs may
    // change freely once the operation has started.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            n_reg   <= 8'h00;
            d_reg   <= 4'h0;
            r_reg   <= 5'h00;
            q_reg   <= 8'h00;
            cnt_reg <= 3'd0;
        end else if (accept) begin
            n_reg   <= dividend;
            d_reg   <= divisor;
            r_reg   <= 5'h00;
            q_reg   <= 8'h00;
            cnt_reg <= 3'd7;
        end else if (state_reg == CALC) begin
            r_reg   <= r_step;
            q_reg   <= q_step;
            cnt_reg <= cnt_reg - 3'd1;
        end
    end

    // Result registers. They change only when an operation completes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            quotient_reg  <= 8'h00;
            remainder_reg <= 4'h0;
        end else if (accept && div_zero) begin
            quotient_reg  <= 8'hFF;
            remainder_reg <= dividend[3:0];
        end else if (last_iter) begin
            quotient_reg  <= q_step;
            remainder_reg <= r_step[3:0];
        end
    end

`ifdef FOUR_BIT_SEQ_DIVIDER_DZ_EN
    logic dz_reg;

    // Divide-by-zero flag. It is set on a zero-divisor accept and cleared
    // when a normal operation completes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dz_reg <= 1'b0;
        end else if (accept && div_zero) begin
            dz_reg <= 1'b1;
        end else if (last_iter) begin
            dz_reg <= 1'b0;
        end
    end

    assign dz = dz_reg;
`else
    assign dz = 1'b0;
`endif

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Testbench for four_bit_seq_divider. It uses table-driven vectors with a
// result scoreboard, plus hand-written sequences for the ignored-start case
// and the mid-operation reset case, and an exhaustive nonzero-divisor sweep.
module tb_four_bit_seq_divider;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [3:0] divisor = 4'h0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dz;

    four_bit_seq_divider dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         passes = 0;
    int         done_count = 0;
    logic       done_prev = 1'b0;
    int         e0 = 0;
    logic [7:0] last_q = 8'h00;
    logic [3:0] last_r = 4'h0;

`ifdef FOUR_BIT_SEQ_DIVIDER_DZ_EN
    localparam logic DZ_EXP  = 1'b1;
    localparam int   DZ_LAT  = 0;
`else
    localparam logic DZ_EXP  = 1'b0;
    localparam int   DZ_LAT  = 8;
`endif

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Scoreboard monitor: each done pulse pops one expected result and compares it.
    always @(negedge clk) begin
        if (clr && done) begin
            done_count++;
            chk("done_single_cycle", int'(done_prev), 0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_quotient", int'(quotient), int'(mon_e.q));
                chk("sb_remainder", int'(remainder), int'(mon_e.r));
                chk("sb_dz", int'(dz), int'(mon_e.z));
                $display("op done: q=0x%02h r=0x%01h dz=%0d", quotient, remainder, dz);
            end
        end
        done_prev = done;
    end

    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e0       = cyc;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk({name, "_latency"}, cyc - e0, exp_lat);
            @(negedge clk);
            chk({name, "_busy_low"}, int'(busy), 0);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] q, input logic [3:0] r, input logic z,
                          input int lat);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        sb.push_back(e);
        start_op(a, b);
        if (lat > 0) begin
            @(negedge clk);
            chk({name, "_busy_high"}, int'(busy), 1);
            chk({name, "_hold_q"}, int'(quotient), int'(last_q));
            chk({name, "_hold_r"}, int'(remainder), int'(last_r));
        end
        wait_done(name, lat);
        last_q = q;
        last_r = r;
    endtask

    vec_t vecs[6];

    initial begin
        int dc;
        exp_t e;

        vecs[0] = '{"e1_f",  8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0,   8};
        vecs[1] = '{"8f_a",  8'h8F, 4'hA, 8'h0E, 4'h3, 1'b0,   8};
        vecs[2] = '{"ff_1",  8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0,   8};
        vecs[3] = '{"05_9",  8'h05, 4'h9, 8'h00, 4'h5, 1'b0,   8};
        vecs[4] = '{"2a_0",  8'h2A, 4'h0, 8'hFF, 4'hA, DZ_EXP, DZ_LAT};
        vecs[5] = '{"10_3",  8'h10, 4'h3, 8'h05, 4'h1, 1'b0,   8};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(dz), 0);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].name, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
                   vecs[i].z, vecs[i].lat);
            repeat (3) @(negedge clk);
            chk({vecs[i].name, "_idle_hold_q"}, int'(quotient), int'(vecs[i].q));
            chk({vecs[i].name, "_idle_hold_r"}, int'(remainder), int'(vecs[i].r));
        end

        // A start pulse during CALC is ignored and not queued.
        e.q = 8'h0E; e.r = 4'h2; e.z = 1'b0;
        sb.push_back(e);
        start_op(8'h64, 4'h7);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'hFF; divisor = 4'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", 8);
        dc = done_count;
        repeat (15) @(negedge clk);
        chk("ignore_no_second_done", done_count, dc);
        chk("ignore_idle_busy", int'(busy), 0);
        last_q = 8'h0E; last_r = 4'h2;

        // Asynchronous reset in the middle of an operation.
        e.q = 8'h28; e.r = 4'h0; e.z = 1'b0;
        sb.push_back(e);
        start_op(8'hC8, 4'h5);
        repeat (4) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_dz", int'(dz), 0);
        sb.delete();
        dc = done_count;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_count, dc);
        clr = 1'b1;
        last_q = 8'h00; last_r = 4'h0;
        run_op("after_abort", 8'hC8, 4'h5, 8'h28, 4'h0, 1'b0, 8);

        // Exhaustive sweep over all nonzero divisors.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op("sweep", 8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 8);
                chk("sweep_identity", int'(quotient) * b + int'(remainder), a);
                chk("sweep_rem_lt_div", int'(int'(remainder) < b), 1);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
